// File: rtl/msg_stream_checker.sv
// Receive-side checker for the generator's "Guatemala" / "QQuetza" banner stream.
// Hunts for a start byte, tracks position, counts good frames and reports lock/errors.
module msg_stream_checker #(
    parameter int CNT_W       = 8,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             in_valid,
    output logic             msg_id,
    output logic [3:0]       pos,
    output logic             frame_done,
    output logic             err,
    output logic             locked,
    output logic [CNT_W-1:0] frame_count
);

    localparam logic [1:0] S_HUNT    = 2'd0;
    localparam logic [1:0] S_TRACK_A = 2'd1;
    localparam logic [1:0] S_TRACK_B = 2'd2;

    localparam logic [7:0] START_A  = 8'h47;
    localparam logic [7:0] START_B  = 8'h51;
    localparam logic [3:0] LAST_A   = 4'd8;
    localparam logic [3:0] LAST_B   = 4'd6;
    localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

    function automatic logic [7:0] tbl_byte(input logic is_b, input logic [3:0] p);
        logic [7:0] b;
        b = 8'h00;
        if (!is_b) begin
            case (p)
                4'd0: b = 8'h47;
                4'd1: b = 8'h75;
                4'd2: b = 8'h61;
                4'd3: b = 8'h74;
                4'd4: b = 8'h65;
                4'd5: b = 8'h6D;
                4'd6: b = 8'h61;
                4'd7: b = 8'h6C;
                4'd8: b = 8'h61;
                default: b = 8'h00;
            endcase
        end else begin
            case (p)
                4'd0: b = 8'h51;
                4'd1: b = 8'h51;
                4'd2: b = 8'h75;
                4'd3: b = 8'h65;
                4'd4: b = 8'h74;
                4'd5: b = 8'h7A;
                4'd6: b = 8'h61;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [3:0]       pos_q, pos_d;
    logic             msg_id_q, msg_id_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;
    logic [3:0]       lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;

    logic             cur_b;
    logic [7:0]       exp_byte;
    logic [3:0]       last_pos;
    logic [1:0]       hunt_state;
    logic [3:0]       hunt_pos;
    logic             hunt_id;
    logic             is_start;

    always_comb begin
        cur_b    = (state_q == S_TRACK_B);
        exp_byte = tbl_byte(cur_b, pos_q);
        last_pos = cur_b ? LAST_B : LAST_A;
        is_start = (data_in == START_A) || (data_in == START_B);

        // What the current byte would do if we were hunting
        hunt_state = S_HUNT;
        hunt_pos   = 4'd0;
        hunt_id    = msg_id_q;
        if (data_in == START_A) begin
            hunt_state = S_TRACK_A;
            hunt_pos   = 4'd1;
            hunt_id    = 1'b0;
        end else if (data_in == START_B) begin
            hunt_state = S_TRACK_B;
            hunt_pos   = 4'd1;
            hunt_id    = 1'b1;
        end

        state_d       = state_q;
        pos_d         = pos_q;
        msg_id_d      = msg_id_q;
        frame_done_d  = 1'b0;
        err_d         = 1'b0;
        lock_cnt_d    = lock_cnt_q;
        frame_count_d = frame_count_q;

        if (in_valid) begin
            if (state_q == S_HUNT) begin
                state_d  = hunt_state;
                pos_d    = hunt_pos;
                msg_id_d = hunt_id;
            end else if (pos_q == 4'd0) begin
                if (is_start) begin
                    if (hunt_id != cur_b) begin
                        lock_cnt_d = 4'd0;
                    end
                    state_d  = hunt_state;
                    pos_d    = hunt_pos;
                    msg_id_d = hunt_id;
                end else begin
                    err_d      = 1'b1;
                    lock_cnt_d = 4'd0;
                    state_d    = S_HUNT;
                    pos_d      = 4'd0;
                end
            end else if (data_in == exp_byte) begin
                if (pos_q == last_pos) begin
                    pos_d         = 4'd0;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + CNT_W'(1);
                    if (lock_cnt_q < LOCK_MAX) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end
                end else begin
                    pos_d = pos_q + 4'd1;
                end
            end else begin
                err_d      = 1'b1;
                lock_cnt_d = 4'd0;
                // "QQQ": the last two bytes still form a valid B prefix
                if (!(cur_b && pos_q == 4'd2 && data_in == START_B)) begin
                    state_d  = hunt_state;
                    pos_d    = hunt_pos;
                    msg_id_d = hunt_id;
                end
            end
        end

        locked_d = (lock_cnt_d == LOCK_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_HUNT;
            pos_q         <= 4'd0;
            msg_id_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
            lock_cnt_q    <= 4'd0;
            locked_q      <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            msg_id_q      <= msg_id_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
            lock_cnt_q    <= lock_cnt_d;
            locked_q      <= locked_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign msg_id      = msg_id_q;
    assign pos         = pos_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;
    assign locked      = locked_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_msg_stream_checker.sv
// Bench for msg_stream_checker: directed scenarios plus random streams,
// every cycle compared against a string-based reference model.
module tb_msg_stream_checker;

    localparam int CNT_W = 8;
    localparam int LF    = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       data_in;
    logic             in_valid;
    logic             msg_id;
    logic [3:0]       pos;
    logic             frame_done;
    logic             err;
    logic             locked;
    logic [CNT_W-1:0] frame_count;

    msg_stream_checker #(.CNT_W(CNT_W), .LOCK_FRAMES(LF)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .msg_id     (msg_id),
        .pos        (pos),
        .frame_done (frame_done),
        .err        (err),
        .locked     (locked),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    string msg_a = "Guatemala";
    string msg_b = "QQuetza";

    // Reference model: mode 0 = hunting, 1 = message A, 2 = message B
    int m_mode, m_pos, m_lock, m_count;
    bit m_id, m_fd, m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] msg_byte(input int mode, input int p);
        if (mode == 1) return msg_a[p];
        return msg_b[p];
    endfunction

    function automatic int msg_len(input int mode);
        if (mode == 1) return msg_a.len();
        return msg_b.len();
    endfunction

    task automatic m_reset();
        m_mode = 0; m_pos = 0; m_lock = 0; m_count = 0;
        m_id = 0; m_fd = 0; m_err = 0;
    endtask

    task automatic m_hunt(input logic [7:0] d);
        if (d == msg_a[0]) begin
            m_mode = 1; m_pos = 1; m_id = 0;
        end else if (d == msg_b[0]) begin
            m_mode = 2; m_pos = 1; m_id = 1;
        end else begin
            m_mode = 0; m_pos = 0;
        end
    endtask

    task automatic m_step(input logic [7:0] d, input bit v);
        m_fd  = 0;
        m_err = 0;
        if (!v) return;
        if (m_mode == 0) begin
            m_hunt(d);
        end else if (m_pos == 0) begin
            if (d == msg_a[0] || d == msg_b[0]) begin
                if (d != msg_byte(m_mode, 0)) m_lock = 0;
                m_hunt(d);
            end else begin
                m_err = 1; m_lock = 0; m_mode = 0; m_pos = 0;
            end
        end else if (d == msg_byte(m_mode, m_pos)) begin
            m_pos++;
            if (m_pos == msg_len(m_mode)) begin
                m_pos   = 0;
                m_fd    = 1;
                m_count = (m_count + 1) % (1 << CNT_W);
                if (m_lock < LF) m_lock++;
            end
        end else begin
            m_err  = 1;
            m_lock = 0;
            if (!(m_mode == 2 && m_pos == 2 && d == msg_b[0])) m_hunt(d);
        end
    endtask

    task automatic check_all();
        check("msg_id", 32'(msg_id), 32'(m_id));
        check("pos", 32'(pos), 32'(m_pos));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("err", 32'(err), 32'(m_err));
        check("locked", 32'(locked), 32'(m_lock == LF));
        check("frame_count", 32'(frame_count), 32'(m_count));
        check("fd_err_excl", 32'(frame_done & err), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_msg_id"}, 32'(msg_id), 32'd0);
        check({tag, "_pos"}, 32'(pos), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    task automatic step(input logic [7:0] d, input bit v);
        @(negedge clk);
        data_in  = d;
        in_valid = v;
        @(posedge clk);
        m_step(d, v);
        #1;
        check_all();
    endtask

    task automatic send_frame(input int mode, input bit gaps);
        for (int i = 0; i < msg_len(mode); i++) begin
            if (gaps && $urandom_range(0, 7) == 0) step(8'($urandom), 1'b0);
            step(msg_byte(mode, i), 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        m_reset();
        check_zero("reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = 8'h00;
        m_reset();
        #2;
        check_zero("por");
        do_reset();

        // Three A frames back to back
        for (int f = 0; f < 3; f++) send_frame(1, 1'b0);
        check("a3_count", 32'(frame_count), 32'd3);
        check("a3_locked", 32'(locked), 32'd1);

        // Switch to B at the boundary, then QQQ case
        for (int f = 0; f < 3; f++) send_frame(2, 1'b0);
        check("b_msg_id", 32'(msg_id), 32'd1);
        begin
            logic [7:0] qs [8] = '{8'h51, 8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61};
            for (int i = 0; i < 8; i++) step(qs[i], 1'b1);
        end

        // Corrupted A frame, then recovery
        do_reset();
        for (int i = 0; i < 9; i++) step(i == 4 ? 8'h41 : msg_byte(1, i), 1'b1);
        for (int f = 0; f < 3; f++) send_frame(1, 1'b0);

        // Idle gap mid-frame
        for (int i = 0; i < 9; i++) begin
            step(msg_byte(1, i), 1'b1);
            if (i == 3) for (int g = 0; g < 3; g++) step(8'h47, 1'b0);
        end

        // Locked on A, then B from the boundary
        send_frame(1, 1'b0);
        send_frame(1, 1'b0);
        for (int f = 0; f < 3; f++) send_frame(2, 1'b0);

        // Async reset at pos 5
        for (int i = 0; i < 5; i++) step(msg_byte(1, i), 1'b1);
        check("pre_rst_pos", 32'(pos), 32'd5);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(8'h6D, 1'b1);
        step(8'h61, 1'b1);
        send_frame(1, 1'b0);

        // Random mix of clean, corrupt and junk traffic
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                send_frame(1, 1'b1);
            end else if (r <= 6) begin
                send_frame(2, 1'b1);
            end else if (r == 7) begin
                int mode, bad;
                mode = $urandom_range(1, 2);
                bad  = $urandom_range(0, msg_len(mode) - 1);
                for (int i = 0; i < msg_len(mode); i++)
                    step(i == bad ? 8'($urandom) : msg_byte(mode, i), 1'b1);
            end else if (r == 8) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                    step(8'($urandom), 1'b1);
            end else begin
                step(8'($urandom), 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/msg_stream_checker.md
Name: msg_stream_checker

Overview:
- Receive-side checker for the 8-bit ASCII banner stream produced by the chip's message generator.
- The generator cycles one byte per clock through one of two fixed messages:
  - Message A, "Guatemala": 47 75 61 74 65 6D 61 6C 61 (9 bytes).
  - Message B, "QQuetza": 51 51 75 65 74 7A 61 (7 bytes).
- This block hunts for a message start, tracks byte position, identifies which message is running, counts complete frames, declares lock, and flags corrupted bytes.
- Sits downstream of the generator output, or on a loopback/test header.

Parameters:
- CNT_W, 8, width of frame_count; wraps modulo 2^CNT_W.
- LOCK_FRAMES, 2, consecutive error-free complete frames of the same message required to assert locked (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  8  received byte.
- in_valid  input  1  data_in is sampled only when high; tie high for the free-running generator.
- msg_id  output  1  0 = message A, 1 = message B; identity of the message being tracked.
- pos  output  4  index of the next expected byte within the current message (0..8 for A, 0..6 for B).
- frame_done  output  1  one-cycle pulse, a complete message was received without error.
- err  output  1  one-cycle pulse, byte mismatch.
- locked  output  1  LOCK_FRAMES consecutive good frames of the same msg_id seen.
- frame_count  output  CNT_W  total good frames received since reset.

Behaviour:
- Reset: clk is clk; reset is reset, asynchronous, active-high. While reset is high, all outputs are 0 and the FSM is in HUNT. The lock counter clears.
- All outputs are registered. The response to an accepted byte appears in the cycle after the rising edge that samples it.
- Cycles with in_valid=0: no state, counter, or output change, except that frame_done and err return to 0.
- States: HUNT, TRACK_A, TRACK_B.
- HUNT:
  - Byte 0x47 -> TRACK_A, pos=1, msg_id=0.
  - Byte 0x51 -> TRACK_B, pos=1, msg_id=1.
  - Any other byte -> remain in HUNT, no err.
- TRACK_x at pos>0, byte equals table[pos]:
  - pos increments.
  - On the last index (8 for A, 6 for B): pos=0, frame_done=1, frame_count+1 (wrapping), lock counter +1 (saturating at LOCK_FRAMES). locked=1 once the counter reaches LOCK_FRAMES.
- TRACK_x at pos>0, mismatch:
  - err=1, lock counter=0, locked=0.
  - The current byte is re-evaluated as in HUNT: 0x47 -> TRACK_A pos=1; 0x51 -> TRACK_B pos=1; otherwise -> HUNT.
  - Exception: TRACK_B at pos=2 receiving 0x51 stays in TRACK_B with pos=2. The last two bytes were QQ, so alignment is kept; err still pulses.
- TRACK_x at pos=0 (frame boundary):
  - Start byte of the same message -> pos=1, no err.
  - Start byte of the other message -> switch state and msg_id, pos=1, lock counter=0, locked=0, no err.
  - Any other byte -> err=1, lock counter=0, locked=0, go to HUNT.
- frame_done and err never assert in the same cycle.
- frame_count does not change on error.
- pos always reflects the post-update value.
- Reset mid-frame: immediate return to the reset state; no frame_done is emitted for the partial frame.

Test Plan:
- Three back-to-back A frames, in_valid=1 -> frame_done pulses 9 cycles apart; locked=1 after the 2nd pulse; msg_id=0; frame_count=3; err never high.
- Continuous B frames -> frame_done every 7 cycles; msg_id=1; locked after 2 frames. Stream 51 51 51 75 65 74 7A 61 -> one err pulse at the 3rd 0x51, then frame_done at the final 0x61.
- A stream with byte index 4 (0x65) replaced by 0x41 -> err pulse one cycle later; locked=0; FSM in HUNT; frame_count unchanged. The next clean A frame gives frame_done; locked needs 2 more good frames.
- in_valid low for 3 cycles mid-frame (after byte index 3) -> pos holds at 4; the frame still completes with frame_done and no err.
- Two A frames (locked=1), then B frames from the boundary -> no err; locked drops at the first 0x51; msg_id=1; locked reasserts after 2 B frames.
- Assert reset asynchronously at pos=5 of an A frame -> all outputs 0 before the next clk edge. After release, the stream resyncs on the next 0x47.
